// File: rtl/kernel_bank_pkg.sv
// Shared types and preset kernels for the kernel_bank coefficient store.
// Presets are 3x3 row-major; kernel_bank centres them for larger kernel sizes.
package kernel_pkg;

  typedef enum logic [2:0] {
    KID_IDENTITY = 3'd0,
    KID_GAUSS    = 3'd1,
    KID_SHARPEN  = 3'd2,
    KID_RIDGE    = 3'd3,
    KID_SOBEL_X  = 3'd4,
    KID_SOBEL_Y  = 3'd5,
    KID_CUSTOM   = 3'd6,
    KID_RESERVED = 3'd7
  } kernel_id_t;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_t;

  localparam int PRESET_NUM = 6;

  localparam int PRESET_COEF [0:PRESET_NUM-1][0:8] = '{
    '{ 0,  0,  0,  0,  1,  0,  0,  0,  0},
    '{ 1,  2,  1,  2,  4,  2,  1,  2,  1},
    '{ 0, -1,  0, -1,  5, -1,  0, -1,  0},
    '{-1, -1, -1, -1,  8, -1, -1, -1, -1},
    '{ 1,  0, -1,  2,  0, -2,  1,  0, -1},
    '{-1, -2, -1,  0,  0,  0,  1,  2,  1}
  };

  localparam int PRESET_SHIFT [0:PRESET_NUM-1] = '{0, 4, 0, 0, 0, 0};

  // Custom and reserved IDs fall back to identity here; the custom path is overlaid by the top.
  function automatic int preset_at(input logic [2:0] id, input int r, input int c,
                                   input int ksize);
    int off;
    int rr;
    int cc;
    int pid;
    off = (ksize - 3) / 2;
    rr  = r - off;
    cc  = c - off;
    pid = (id > 3'd5) ? 0 : int'(id);
    if (rr < 0 || rr > 2 || cc < 0 || cc > 2) return 0;
    return PRESET_COEF[pid][rr*3+cc];
  endfunction

  function automatic int preset_shift(input logic [2:0] id);
    int pid;
    pid = (id > 3'd5) ? 0 : int'(id);
    return PRESET_SHIFT[pid];
  endfunction

endpackage

// File: rtl/kernel_bank_if.sv
// Custom-kernel load stream between the register/UART logic and kernel_bank.
interface kernel_bank_if #(
  parameter int COEFF_W = 8
) ();
  logic [COEFF_W-1:0] wr_data_in;
  logic               wr_valid_in;
  logic               wr_last_in;
  logic               wr_ready_out;

  modport master (output wr_data_in, wr_valid_in, wr_last_in, input wr_ready_out);
  modport slave  (input wr_data_in, wr_valid_in, wr_last_in, output wr_ready_out);
endinterface

// File: rtl/kernel_bank_loader.sv
// Custom-kernel loader: collects K_SIZE*K_SIZE coefficients plus a shift word,
// and only replaces the staged kernel when the stream is well-formed.
module kernel_loader
  import kernel_pkg::*;
#(
  parameter int K_SIZE  = 3,
  parameter int COEFF_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  kernel_bank_if.slave                      ld_if,
  output logic [K_SIZE*K_SIZE*COEFF_W-1:0]  staged_coeffs_o,
  output logic [SHIFT_W-1:0]                staged_shift_o,
  output logic                              stage_done_o,
  output logic                              load_err_o
);
  localparam int NW    = K_SIZE * K_SIZE;
  localparam int VW    = NW * COEFF_W;
  localparam int IDX_W = $clog2(NW + 1);

  function automatic logic [VW-1:0] identity_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int r = 0; r < K_SIZE; r++)
      for (int c = 0; c < K_SIZE; c++)
        v[(r*K_SIZE+c)*COEFF_W +: COEFF_W] = COEFF_W'(preset_at(KID_IDENTITY, r, c, K_SIZE));
    return v;
  endfunction

  localparam logic [VW-1:0] ID_VEC = identity_vec();

  ld_state_t          state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [VW-1:0]      work_q;
  logic [VW-1:0]      staged_q;
  logic [SHIFT_W-1:0] staged_shift_q;
  logic               err_q;
  logic               shift_word;

  // The loader never stalls, so every valid word is accepted.
  assign ld_if.wr_ready_out = 1'b1;
  assign shift_word         = (state_q == LD_LOAD) && (idx_q == IDX_W'(NW));
  assign stage_done_o       = ld_if.wr_valid_in && ld_if.wr_last_in && shift_word;
  assign staged_coeffs_o    = staged_q;
  assign staged_shift_o     = staged_shift_q;
  assign load_err_o         = err_q;

  // Words go to a scratch buffer so a malformed stream never touches the staged kernel.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= LD_IDLE;
      idx_q          <= '0;
      work_q         <= '0;
      staged_q       <= ID_VEC;
      staged_shift_q <= '0;
      err_q          <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (ld_if.wr_valid_in) begin
        case (state_q)
          LD_IDLE: begin
            work_q[0 +: COEFF_W] <= ld_if.wr_data_in;
            if (ld_if.wr_last_in) begin
              err_q <= 1'b1;
            end else begin
              state_q <= LD_LOAD;
              idx_q   <= IDX_W'(1);
            end
          end
          LD_LOAD: begin
            if (shift_word) begin
              state_q <= LD_IDLE;
              idx_q   <= '0;
              if (ld_if.wr_last_in) begin
                staged_q       <= work_q;
                staged_shift_q <= ld_if.wr_data_in[SHIFT_W-1:0];
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              work_q[int'(idx_q)*COEFF_W +: COEFF_W] <= ld_if.wr_data_in;
              if (ld_if.wr_last_in) begin
                err_q   <= 1'b1;
                state_q <= LD_IDLE;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/kernel_bank.sv
// Frame-synchronous convolution kernel store: six presets plus an optional custom
// kernel (built when KERNEL_BANK_CUSTOM_EN is defined), committed on frame_start_in.
module kernel_bank
  import kernel_pkg::*;
#(
  parameter int K_SIZE  = 3,
  parameter int COEFF_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [2:0]                        sel_in,
  input  logic                              sel_valid_in,
  input  logic                              frame_start_in,
  kernel_bank_if.slave                      ld_if,
  output logic [K_SIZE*K_SIZE*COEFF_W-1:0]  coeffs_out,
  output logic [SHIFT_W-1:0]                shift_out,
  output logic [2:0]                        active_sel_out,
  output logic                              kernel_valid_out,
  output logic                              load_err_out
);
  localparam int NW = K_SIZE * K_SIZE;
  localparam int VW = NW * COEFF_W;

  function automatic logic [VW-1:0] preset_vec(input logic [2:0] id);
    logic [VW-1:0] v;
    v = '0;
    for (int r = 0; r < K_SIZE; r++)
      for (int c = 0; c < K_SIZE; c++)
        v[(r*K_SIZE+c)*COEFF_W +: COEFF_W] = COEFF_W'(preset_at(id, r, c, K_SIZE));
    return v;
  endfunction

  logic [2:0]         pending_q;
  logic [2:0]         active_sel_q;
  logic [2:0]         commit_sel;
  logic [VW-1:0]      coeffs_q;
  logic [VW-1:0]      coeffs_d;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] shift_d;
  logic               valid_q;

`ifdef KERNEL_BANK_CUSTOM_EN
  localparam logic [VW-1:0] ID_VEC = preset_vec(KID_IDENTITY);

  logic [VW-1:0]      staged_coeffs;
  logic [SHIFT_W-1:0] staged_shift;
  logic               stage_done;
  logic               load_err;
  logic               staged_q;
  logic [VW-1:0]      custom_active_q;
  logic [SHIFT_W-1:0] custom_shift_q;
  logic [VW-1:0]      custom_src;
  logic [SHIFT_W-1:0] custom_src_shift;

  kernel_loader #(
    .K_SIZE  (K_SIZE),
    .COEFF_W (COEFF_W),
    .SHIFT_W (SHIFT_W)
  ) u_loader (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .ld_if           (ld_if),
    .staged_coeffs_o (staged_coeffs),
    .staged_shift_o  (staged_shift),
    .stage_done_o    (stage_done),
    .load_err_o      (load_err)
  );

  // A kernel staged in the very cycle of frame_start_in waits for the next frame.
  assign custom_src       = staged_q ? staged_coeffs : custom_active_q;
  assign custom_src_shift = staged_q ? staged_shift  : custom_shift_q;
  assign load_err_out     = load_err;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      staged_q        <= 1'b0;
      custom_active_q <= ID_VEC;
      custom_shift_q  <= '0;
    end else begin
      if (frame_start_in && staged_q) begin
        custom_active_q <= staged_coeffs;
        custom_shift_q  <= staged_shift;
      end
      if (stage_done) begin
        staged_q <= 1'b1;
      end else if (frame_start_in) begin
        staged_q <= 1'b0;
      end
    end
  end
`else
  logic unused_ld;

  assign ld_if.wr_ready_out = 1'b0;
  assign load_err_out       = 1'b0;
  assign unused_ld          = ^{ld_if.wr_data_in, ld_if.wr_valid_in, ld_if.wr_last_in};
`endif

  always_comb begin
    commit_sel = sel_valid_in ? sel_in : pending_q;
    coeffs_d   = preset_vec(commit_sel);
    shift_d    = SHIFT_W'(preset_shift(commit_sel));
`ifdef KERNEL_BANK_CUSTOM_EN
    if (commit_sel == KID_CUSTOM) begin
      coeffs_d = custom_src;
      shift_d  = custom_src_shift;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_q    <= '0;
      active_sel_q <= '0;
      coeffs_q     <= '0;
      shift_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      if (sel_valid_in) pending_q <= sel_in;
      if (frame_start_in) begin
        active_sel_q <= commit_sel;
        coeffs_q     <= coeffs_d;
        shift_q      <= shift_d;
        valid_q      <= 1'b1;
      end
    end
  end

  assign coeffs_out       = coeffs_q;
  assign shift_out        = shift_q;
  assign active_sel_out   = active_sel_q;
  assign kernel_valid_out = valid_q;

endmodule

// File: doc/kernel_bank.md
# kernel_bank

Runtime-selectable convolution kernel store for the video filter pipeline. It holds six fixed presets plus one user-loadable custom kernel, and accepts kernel-select and custom-load requests at any time. Changes are committed to the convolution datapath only on a frame boundary, so a frame is never filtered with a mix of two kernels. It sits between the control/UART register logic and the convolution core, and drives that core's coefficient and shift inputs.

## Interface

Parameters:
- K_SIZE, 3: kernel edge length; odd, 3 or 5.
- COEFF_W, 8: signed coefficient width.
- SHIFT_W, 4: unsigned right-shift width.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- sel_in  input  3  requested kernel ID.
- sel_valid_in  input  1  one-cycle strobe that latches sel_in as the pending kernel.
- frame_start_in  input  1  one-cycle strobe at start of frame; this is the commit point.
- wr_data_in  input  COEFF_W  custom-load data word.
- wr_valid_in  input  1  custom-load word valid.
- wr_last_in  input  1  marks the final word of the custom-load stream.
- wr_ready_out  output  1  custom loader can accept a word.
- coeffs_out  output  K_SIZE*K_SIZE*COEFF_W  active kernel. Element (r,c) occupies bits [(r*K_SIZE+c)*COEFF_W +: COEFF_W].
- shift_out  output  SHIFT_W  active normalisation shift.
- active_sel_out  output  3  ID of the committed kernel.
- kernel_valid_out  output  1  high once the first commit has occurred.
- load_err_out  output  1  one-cycle pulse on a malformed custom load.

## Operation

- Kernel IDs and shifts:
  - 0 identity, shift 0.
  - 1 Gaussian 1-2-1/2-4-2/1-2-1, shift 4.
  - 2 sharpen 0,-1,0/-1,5,-1/0,-1,0, shift 0.
  - 3 ridge (-1 all around, 8 centre), shift 0.
  - 4 Sobel X 1,0,-1/2,0,-2/1,0,-1, shift 0.
  - 5 Sobel Y -1,-2,-1/0,0,0/1,2,1, shift 0.
  - 6 custom.
  - 7 reserved; decodes as identity.
- When K_SIZE=5, each 3x3 preset is centred in the 5x5 grid and the outer ring is zero.
- Pending select: on sel_valid_in, pending_sel <= sel_in. If several strobes arrive before a commit, the last one wins.
- Commit: on frame_start_in, active_sel <= pending_sel. If custom_staged is set, custom_active <= custom_staged_buf and custom_staged is cleared. The output registers are reloaded from the decoded active kernel.
- If sel_valid_in and frame_start_in occur in the same cycle, sel_in is committed directly (bypasses pending_sel).
- Custom loader FSM:
  - IDLE: wr_ready_out=1. The first accepted word moves to LOAD with idx=1.
  - LOAD: words are accepted (wr_valid_in & wr_ready_out) in row-major order, idx = 0..K_SIZE*K_SIZE-1. Word K_SIZE*K_SIZE is the shift; its low SHIFT_W bits are used.
  - The load is well-formed only if wr_last_in is asserted exactly on word K_SIZE*K_SIZE. On that word: custom_staged <= 1 and the FSM returns to IDLE.
  - wr_last_in on any earlier word, or no wr_last_in on the shift word: pulse load_err_out, discard the staging buffer (custom_staged unchanged), return to IDLE.
  - wr_ready_out stays 1 in IDLE and LOAD. The loader never stalls.
- If the final custom word and frame_start_in occur in the same cycle, the commit uses the previous staged state. The new custom kernel commits at the next frame_start_in.
- Reset: all state clears. custom_active and custom_staged_buf reset to the identity kernel; the FSM goes to IDLE.

## Timing

- Output reset values: coeffs_out=0, shift_out=0, active_sel_out=0, kernel_valid_out=0, load_err_out=0, wr_ready_out=1.
- Commit latency: a frame_start_in sampled at edge t updates coeffs_out, shift_out and active_sel_out after edge t, so they are valid in cycle t+1. kernel_valid_out rises at the same edge.
- All outputs are registered. There is no combinational path from any input to any output.
- load_err_out is asserted in the cycle after the offending word is accepted.
- Outputs hold steady between commits regardless of sel or wr activity.

## Configuration

- Macro: KERNEL_BANK_CUSTOM_EN.
- Defined: loader FSM, staging buffer and custom_active are built; ID 6 is custom.
- Undefined: no loader is built. wr_ready_out is tied 0, load_err_out is tied 0, and ID 6 decodes as identity.

## Structure

- Package kernel_pkg holds:
  - kernel ID enum kernel_id_t (KID_IDENTITY..KID_RESERVED);
  - loader state enum;
  - the six preset 3x3 coefficient constants and their shift constants.
- Sub-module kernel_loader holds the custom-load FSM, index counter and staging buffer. It exports the staged kernel, staged shift, a stage-done pulse and the error pulse.

## Test plan

- Reset, then frame_start_in with no select: outputs are 0 during reset, then identity after commit (centre=1, shift 0, kernel_valid_out=1).
- sel_valid_in with sel_in=1, outputs observed before and after frame_start_in: unchanged until commit, then Gaussian with shift_out=4 one cycle after the strobe.
- sel_valid_in with sel_in=4 then sel_in=5 in the same frame: Sobel Y is committed.
- Custom load of ten words (1..9, then shift 3) with wr_last_in on word 10, sel 6, frame_start_in: coeffs_out[0]=1, coeffs_out[8]=9, shift_out=3.
- wr_last_in on word 5: load_err_out pulses; the next commit keeps the previous custom kernel.
- Final custom word in the same cycle as frame_start_in: the old custom kernel is committed; the new one appears after the following frame_start_in.
